// File: rtl/wb_dma_master_pkg.sv
// Shared definitions for the Wishbone block-copy DMA master.
package wb_dma_master_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StRgap = 3'd2,
    StWr   = 3'd3,
    StWgap = 3'd4
  } dma_state_e;

  localparam logic [31:0] ADDR_STEP = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/wb_dma_master_if.sv
// Wishbone bus signals between the DMA master and WB_intercon.
interface wb_dma_master_if;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        ACK;

  modport master (output STB, WE, ADDR, DAT_O, input DAT_I, ACK);
  modport slave  (input STB, WE, ADDR, DAT_O, output DAT_I, ACK);
endinterface

// File: rtl/wb_ack_timeout.sv
// Wait-state counter; flags the cycle in which the TIMEOUT-th unacknowledged cycle completes.
module wb_ack_timeout
  import wb_dma_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires one cycle early so the bus drops exactly as the count reaches TIMEOUT.
  assign expired = en && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_dma_master.sv
// Wishbone DMA master: copies cfg_len words from cfg_src to cfg_dst, one read then one write each.
module wb_dma_master
  import wb_dma_master_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          cfg_src,
  input  logic [31:0]          cfg_dst,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 start,
  input  logic                 abort,
  wb_dma_master_if.master      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 INT,
  output logic [LEN_W-1:0]     words_left
);

  dma_state_e       state_q;
  logic             stb_q, we_q;
  logic [31:0]      addr_q, dat_o_q;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] words_left_q;
  logic             busy_q, done_q, err_q;
  logic             abort_pend_q;
  logic             tmo_clr, tmo_en, tmo_expired;

  assign tmo_clr = !stb_q;
  assign tmo_en  = stb_q && !bus.ACK;

  wb_ack_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_ack_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      dat_o_q      <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      data_q       <= '0;
      words_left_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (cfg_len == '0) begin
              done_q <= 1'b1;
            end else begin
              src_q        <= word_align(cfg_src);
              dst_q        <= word_align(cfg_dst);
              words_left_q <= cfg_len;
              abort_pend_q <= 1'b0;
              busy_q       <= 1'b1;
              stb_q        <= 1'b1;
              we_q         <= 1'b0;
              addr_q       <= word_align(cfg_src);
              state_q      <= StRd;
            end
          end
        end
        StRd: begin
          if (bus.ACK) begin
            data_q       <= bus.DAT_I;
            src_q        <= src_q + ADDR_STEP;
            stb_q        <= 1'b0;
            abort_pend_q <= abort;
            state_q      <= StRgap;
          end else if (tmo_expired) begin
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRgap: begin
          // An abort seen at or after the read ACK drops the fetched word.
          if (abort || abort_pend_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= dst_q;
            dat_o_q <= data_q;
            state_q <= StWr;
          end
        end
        StWr: begin
          if (bus.ACK) begin
            dst_q        <= dst_q + ADDR_STEP;
            words_left_q <= words_left_q - 1'b1;
            stb_q        <= 1'b0;
            abort_pend_q <= abort;
            state_q      <= StWgap;
          end else if (tmo_expired) begin
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StWgap: begin
          if (words_left_q == '0 || abort || abort_pend_q) begin
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= src_q;
            state_q <= StRd;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.STB    = stb_q;
  assign bus.WE     = we_q;
  assign bus.ADDR   = addr_q;
  assign bus.DAT_O  = dat_o_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign INT        = done_q | err_q;
  assign words_left = words_left_q;

endmodule

// File: tb/tb_wb_dma_master.sv
// Directed bench for wb_dma_master with a configurable-wait Wishbone slave model.
module tb_wb_dma_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_src = '0;
  logic [31:0] cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err, irq;
  logic [15:0] words_left;

  int checks = 0;
  int errors = 0;

  wb_dma_master_if bus ();

  wb_dma_master #(
    .LEN_W  (16),
    .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_src   (cfg_src),
    .cfg_dst   (cfg_dst),
    .cfg_len   (cfg_len),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .INT       (irq),
    .words_left(words_left)
  );

  always #5 clk = ~clk;

  // Slave model: ACK after wait_n wait cycles, never when ack_en is low.
  int unsigned wait_n = 0;
  bit          ack_en = 1'b1;
  logic [7:0]  wcnt;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'hAAAA_0001;
      32'h0000_1004: return 32'hBBBB_0002;
      32'h0000_1008: return 32'hCCCC_0003;
      default:       return ~a;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!bus.STB || bus.ACK) wcnt <= '0;
    else                     wcnt <= wcnt + 1'b1;
  end

  always_comb begin
    bus.ACK   = bus.STB && ack_en && (wcnt == 8'(wait_n));
    bus.DAT_I = mem_rd(bus.ADDR);
  end

  // Bus monitor, sampled mid-cycle.
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [31:0] rd_addr [64];
  int nwr = 0, nrd = 0, stb_cyc = 0, stab_viol = 0, gap_viol = 0;
  logic stb_p = 1'b0, we_p = 1'b0, ack_p = 1'b0, busy_p = 1'b0;
  logic [31:0] addr_p = '0, dat_p = '0;

  always @(negedge clk) begin
    stb_p  <= bus.STB;
    we_p   <= bus.WE;
    ack_p  <= bus.ACK;
    busy_p <= busy;
    addr_p <= bus.ADDR;
    dat_p  <= bus.DAT_O;
    if (bus.STB) stb_cyc <= stb_cyc + 1;
    if (stb_p && !ack_p && bus.STB &&
        (we_p != bus.WE || addr_p != bus.ADDR || dat_p != bus.DAT_O))
      stab_viol <= stab_viol + 1;
    if ((stb_p && ack_p && bus.STB) || (!stb_p && busy_p && !bus.STB && busy))
      gap_viol <= gap_viol + 1;
    if (bus.STB && bus.ACK) begin
      if (bus.WE) begin
        wr_addr[nwr[5:0]] <= bus.ADDR;
        wr_data[nwr[5:0]] <= bus.DAT_O;
        nwr <= nwr + 1;
      end else begin
        rd_addr[nrd[5:0]] <= bus.ADDR;
        nrd <= nrd + 1;
      end
    end
  end

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    cfg_src = s;
    cfg_dst = d;
    cfg_len = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // k counts clock edges including the one that sampled start.
  task automatic wait_idle(input int budget, output int k);
    k = 1;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.STB, bus.WE, bus.ADDR, bus.DAT_O} !== 66'd0) begin
      errors++;
      $display("FAIL reset_bus: STB=%0b WE=%0b ADDR=%h DAT_O=%h, required all 0",
               bus.STB, bus.WE, bus.ADDR, bus.DAT_O);
    end
    checks++;
    if ({busy, done, err, irq} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: busy/done/err/INT=%b, required 0000", {busy, done, err, irq});
    end
    checks++;
    if (words_left !== 16'd0) begin
      errors++;
      $display("FAIL reset_words_left: got %0d, required 0", words_left);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    int k;
    int wb;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hAAAA_0001;
    exp_d[1] = 32'hBBBB_0002;
    exp_d[2] = 32'hCCCC_0003;
    wait_n = 0;
    wb = nwr;
    kick(32'h0000_1000, 32'h0000_2000, 16'd3);
    wait_idle(100, k);
    checks++;
    if (k != 13) begin
      errors++;
      $display("FAIL zw_latency: done at cycle %0d, required 13", k);
    end
    checks++;
    if ({done, irq, err} !== 3'b110 || words_left !== 16'd0) begin
      errors++;
      $display("FAIL zw_status: done/INT/err=%b words_left=%0d, required 110 and 0",
               {done, irq, err}, words_left);
    end
    @(negedge clk);
    checks++;
    if (nwr - wb != 3) begin
      errors++;
      $display("FAIL zw_write_count: got %0d, required 3", nwr - wb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[wb+i] !== 32'h0000_2000 + 32'(4 * i) || wr_data[wb+i] !== exp_d[i]) begin
        errors++;
        $display("FAIL zw_write%0d: addr=%h data=%h, required addr=%h data=%h", i,
                 wr_addr[wb+i], wr_data[wb+i], 32'h0000_2000 + 32'(4 * i), exp_d[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    int k;
    int wb, sv, gv;
    wait_n = 5;
    wb = nwr;
    sv = stab_viol;
    gv = gap_viol;
    kick(32'h0000_1000, 32'h0000_3000, 16'd2);
    wait_idle(200, k);
    @(negedge clk);
    checks++;
    if (k != 29) begin
      errors++;
      $display("FAIL ws_latency: done at cycle %0d, required 29", k);
    end
    checks++;
    if (stab_viol != sv || gap_viol != gv) begin
      errors++;
      $display("FAIL ws_handshake: stability errs=%0d gap errs=%0d, required 0 and 0",
               stab_viol - sv, gap_viol - gv);
    end
    checks++;
    if (nwr - wb != 2 || wr_addr[wb+1] !== 32'h0000_3004 || wr_data[wb+1] !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL ws_writes: count=%0d last addr=%h data=%h, required 2 3004 bbbb0002",
               nwr - wb, wr_addr[wb+1], wr_data[wb+1]);
    end
    wait_n = 0;
  endtask

  task automatic test_timeout();
    int stb_cnt;
    ack_en  = 1'b0;
    stb_cnt = 0;
    kick(32'h0000_1000, 32'h0000_2000, 16'd5);
    for (int i = 0; i < 40; i++) begin
      if (bus.STB) stb_cnt++;
      if (!busy) break;
      @(negedge clk);
    end
    checks++;
    if (stb_cnt != 8) begin
      errors++;
      $display("FAIL to_stb_cycles: got %0d, required 8", stb_cnt);
    end
    checks++;
    if ({bus.STB, err, busy, done, irq} !== 5'b01001) begin
      errors++;
      $display("FAIL to_status: STB/err/busy/done/INT=%b, required 01001",
               {bus.STB, err, busy, done, irq});
    end
    checks++;
    if (words_left !== 16'd5) begin
      errors++;
      $display("FAIL to_words_left: got %0d, required 5", words_left);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_len_zero();
    int sc;
    sc = stb_cyc;
    kick(32'h0000_1000, 32'h0000_2000, 16'd0);
    checks++;
    if ({done, busy, irq} !== 3'b101) begin
      errors++;
      $display("FAIL len0_status: done/busy/INT=%b, required 101", {done, busy, irq});
    end
    repeat (5) @(negedge clk);
    checks++;
    if (stb_cyc != sc) begin
      errors++;
      $display("FAIL len0_no_bus: STB cycles=%0d, required 0", stb_cyc - sc);
    end
  endtask

  task automatic test_abort();
    int k;
    int wb, rb, n;
    wait_n = 5;
    wb = nwr;
    rb = nrd;
    kick(32'h0000_1000, 32'h0000_4000, 16'd4);
    n = 0;
    while (!(nwr - wb == 1 && bus.STB && !bus.WE) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    abort = 1'b1;
    wait_idle(100, k);
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (nwr - wb != 1 || wr_addr[wb] !== 32'h0000_4000 || wr_data[wb] !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL ab_writes: count=%0d addr=%h data=%h, required 1 4000 aaaa0001",
               nwr - wb, wr_addr[wb], wr_data[wb]);
    end
    checks++;
    if (nrd - rb != 2) begin
      errors++;
      $display("FAIL ab_reads: got %0d, required 2", nrd - rb);
    end
    checks++;
    if ({done, err} !== 2'b10 || words_left !== 16'd3) begin
      errors++;
      $display("FAIL ab_status: done/err=%b words_left=%0d, required 10 and 3",
               {done, err}, words_left);
    end
    wait_n = 0;
  endtask

  task automatic test_wrap();
    int k;
    int wb, rb;
    wb = nwr;
    rb = nrd;
    kick(32'hFFFF_FFFC, 32'h0000_5000, 16'd2);
    wait_idle(100, k);
    @(negedge clk);
    checks++;
    if (rd_addr[rb] !== 32'hFFFF_FFFC || rd_addr[rb+1] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_reads: %h %h, required fffffffc 00000000", rd_addr[rb], rd_addr[rb+1]);
    end
    checks++;
    if (wr_data[wb] !== 32'h0000_0003 || wr_data[wb+1] !== 32'hFFFF_FFFF ||
        wr_addr[wb+1] !== 32'h0000_5004) begin
      errors++;
      $display("FAIL wrap_writes: %h %h @%h, required 00000003 ffffffff @00005004",
               wr_data[wb], wr_data[wb+1], wr_addr[wb+1]);
    end
  endtask

  task automatic test_start_busy();
    int k;
    int wb;
    wb = nwr;
    kick(32'h0000_1000, 32'h0000_6000, 16'd3);
    repeat (2) @(negedge clk);
    cfg_src = 32'h0000_1008;
    cfg_dst = 32'h0000_7000;
    cfg_len = 16'd1;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_idle(100, k);
    @(negedge clk);
    checks++;
    if (nwr - wb != 3 || wr_addr[wb+2] !== 32'h0000_6008 || wr_data[wb] !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL sb_writes: count=%0d last addr=%h first data=%h, required 3 6008 aaaa0001",
               nwr - wb, wr_addr[wb+2], wr_data[wb]);
    end
    checks++;
    if (words_left !== 16'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL sb_status: words_left=%0d done=%0b, required 0 and 1", words_left, done);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    wait_n = 5;
    kick(32'h0000_1000, 32'h0000_2000, 16'd3);
    n = 0;
    while (!(bus.STB && bus.WE) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(bus.STB && bus.WE)) begin
      errors++;
      $display("FAIL rst_reach_wr: STB=%0b WE=%0b, required 1 1", bus.STB, bus.WE);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.STB, busy, done} !== 3'b000 || words_left !== 16'd0 || bus.ADDR !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: STB/busy/done=%b words_left=%0d ADDR=%h, required 000 0 0",
               {bus.STB, busy, done}, words_left, bus.ADDR);
    end
    @(negedge clk);
    rst    = 1'b0;
    wait_n = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_len_zero();
    test_abort();
    test_wrap();
    test_start_busy();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_dma_master.md
Name: wb_dma_master

Overview:
- Wishbone bus initiator that copies a block of 32-bit words from a source byte address to a destination byte address, one read then one write per word.
- Occupies a second master port on WB_intercon, alongside the CPU. Example use: bulk Ram→VRam copies for screen updates.
- Configured by a simple register strobe interface. Raises a level interrupt when the copy finishes, and reports done/error status.

Parameters:
- LEN_W, 16, width of the word-count register (maximum copy = 2^LEN_W-1 words).
- TIMEOUT, 1023, number of cycles without ACK after which a transfer is abandoned with an error.

Ports:
- clk  in  1  system clock (clk100 domain).
- rst  in  1  asynchronous active-high reset.
- cfg_src  in  32  source byte address; bits [1:0] ignored.
- cfg_dst  in  32  destination byte address; bits [1:0] ignored.
- cfg_len  in  LEN_W  number of words to copy.
- start  in  1  single-cycle pulse; latches cfg_* and begins the copy. Ignored while busy.
- abort  in  1  ends the copy at the next safe point.
- STB  out  1  bus strobe (request valid).
- WE  out  1  1 = write, 0 = read.
- ADDR  out  32  word-aligned byte address.
- DAT_O  out  32  write data.
- DAT_I  in  32  read data; valid in the cycle ACK=1.
- ACK  in  1  slave acknowledge.
- busy  out  1  copy in progress.
- done  out  1  sticky; set on completion or abort; cleared by start.
- err  out  1  sticky; set on timeout; cleared by start.
- INT  out  1  equals done|err; level interrupt for the CPU cause logic.
- words_left  out  LEN_W  remaining word count.

Behaviour:
- Reset, asynchronous: state=IDLE; STB=0, WE=0, ADDR=0, DAT_O=0, busy=0, done=0, err=0, INT=0, words_left=0; internal src/dst/data/timeout registers all 0.
- States: IDLE, RD, RGAP, WR, WGAP.
- IDLE:
  - start=1 with cfg_len=0 → remain IDLE, done=1 next cycle, no bus activity.
  - start=1 with cfg_len≠0 → latch src={cfg_src[31:2],2'b00}, dst likewise, words_left=cfg_len; clear done/err; go to RD; busy=1.
- RD: STB=1, WE=0, ADDR=src. Hold until ACK=1. On ACK: capture DAT_I into the data register, src+=4 (wraps modulo 2^32), go to RGAP.
- RGAP: STB=0 for exactly one cycle, then go to WR.
- WR: STB=1, WE=1, ADDR=dst, DAT_O=data. Hold until ACK. On ACK: dst+=4, words_left-=1, go to WGAP.
- WGAP: STB=0 for one cycle. Then:
  - words_left==0 → IDLE, busy=0, done=1.
  - otherwise → RD.
- Handshake rules:
  - STB/WE/ADDR/DAT_O are registered and stay stable from the cycle STB rises until the cycle after ACK is sampled.
  - STB is always low for at least one cycle between transfers, so a level-type ACK held by a slow slave is never double-counted.
  - ACK while STB=0 is ignored.
- Latency: zero-wait-state slave (ACK in the first STB cycle) gives 4 cycles per word; a copy of N words finishes with done=1 at cycle 4N+1 after start.
- Timeout:
  - A counter clears when entering RD or WR and increments each cycle STB=1 with ACK=0.
  - When it reaches TIMEOUT: STB=0, err=1, busy=0, go to IDLE. words_left keeps its value for diagnosis.
- Abort:
  - Sampled in RD/WR only after the pending ACK, and in the GAP states. The in-flight bus cycle is never cut.
  - Abort in RD → the ACK'd read data is discarded.
  - At the next GAP state → IDLE, done=1.
  - Abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- start while busy: ignored, cfg_* not latched.
- rst mid-transfer: STB drops immediately (asynchronous); all state is lost.

Decomposition:
- Shared package: state encoding constants (IDLE=0, RD=1, RGAP=2, WR=3, WGAP=4) and ADDR_STEP=4. The existing bus signal names are reused.
- One sub-module, wb_ack_timeout: a counter with clear, enable and expired output.
- The FSM, address and data registers stay in wb_dma_master.

Test Plan:
- Zero-wait slave: src=0x1000, dst=0x2000, len=3; memory at 0x1000..0x1008 = {A,B,C}. Required: writes of A,B,C to 0x2000, 0x2004, 0x2008; done=1 at cycle 13 after start; INT=1; words_left=0.
- Slave that holds ACK low 5 cycles per access, len=2. Required: ADDR/WE/DAT_O stable through each wait; STB low exactly one cycle between accesses; exactly 2 writes.
- TIMEOUT=8, slave never ACKs. Required: STB high 8 cycles, then STB=0, err=1, busy=0, words_left=len.
- len=0 start. Required: no STB ever asserted; done=1 one cycle later.
- Abort asserted in the middle of the second read, len=4. Required: first word written; the second read completes but is not written; done=1; words_left=3.
- Misc:
  - src=0xFFFFFFFC, len=2: second read at address 0x00000000.
  - start while busy is ignored.
  - rst during WR drops STB in the same cycle.
